// File: rtl/optic_flow_pkg.sv
// optic_flow_pkg
//   Shared definitions for the optic-flow colour sequencer and the
//   single-cycle colour instruction: RGB565 flow-code table, queue entry
//   layout, queue depth and sequencer FSM state encoding.
package optic_flow_pkg;

   localparam int unsigned QUEUE_DEPTH = 2;
   localparam logic [2:0]  MAX_COUNT   = 3'd4;

   // RGB565 colour per 4-bit flow code
   localparam logic [15:0] flowColorLut [16] = '{
      16'h0000, 16'h0400, 16'h8000, 16'h0010,
      16'h8410, 16'h8410, 16'h0410, 16'h8400,
      16'hC618, 16'hF800, 16'h8010, 16'h07E0,
      16'h001F, 16'hFFE0, 16'h07FF, 16'hFFFF
   };

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  count;
   } queue_entry_t;

   localparam logic [0:0] FSM_IDLE = 1'b0;
   localparam logic [0:0] FSM_EMIT = 1'b1;

   typedef enum logic [0:0] {
      ST_IDLE = FSM_IDLE,
      ST_EMIT = FSM_EMIT
   } fsm_state_t;

   function automatic logic [2:0] clamp_count(input logic [2:0] c);
      return (c > MAX_COUNT) ? MAX_COUNT : c;
   endfunction

endpackage

// File: rtl/optic_flow_color_lut.sv
// optic_flow_color_lut
//   Combinational flow byte -> RGB565 pixel pair.
//   flowByte  in  8   flow code byte (two 4-bit codes)
//   pixelPair out 32  {colour(high nibble), colour(low nibble)}
module optic_flow_color_lut
   import optic_flow_pkg::*;
(
   input  logic [7:0]  flowByte,
   output logic [31:0] pixelPair
);

   assign pixelPair = {flowColorLut[flowByte[7:4]], flowColorLut[flowByte[3:0]]};

endmodule

// File: rtl/optic_flow_color_seq.sv
// optic_flow_color_seq
//   Custom-instruction sequencer: buffers packed flow words in a 2-entry
//   queue and streams one RGB565 pixel pair per flow byte over valid/ready.
//   clock       in   1   system clock
//   nReset      in   1   asynchronous active-low reset
//   start       in   1   custom-instruction strobe
//   ciN         in   8   custom-instruction number (responds to customInstructionId)
//   valueA      in   32  four flow bytes, byte 0 emitted first
//   valueB      in   32  [2:0] byte count (5..7 -> 4), [31] statistics read
//   done        out  1   instruction acknowledge pulse
//   result      out  32  statistics value on done, else 0
//   pixelData   out  32  {hi RGB565, lo RGB565}
//   pixelValid  out  1   pixelData valid
//   pixelReady  in   1   downstream accept
//   Optional: OPTIC_FLOW_SEQ_STATS_EN adds an accepted-word counter readable
//   via valueB[31].
module optic_flow_color_seq
   import optic_flow_pkg::*;
#(
   parameter logic [7:0] customInstructionId = 8'd31
) (
   input  logic        clock,
   input  logic        nReset,
   input  logic        start,
   input  logic [7:0]  ciN,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] pixelData,
   output logic        pixelValid,
   input  logic        pixelReady
);

   fsm_state_t   state;
   queue_entry_t q [QUEUE_DEPTH];
   logic         head;
   logic [1:0]   cnt;
   logic [1:0]   cnt_next;
   logic [31:0]  shift_data;
   logic [2:0]   rem;
   logic         pend;
   queue_entry_t pend_entry;
   logic         done_q;
   logic [31:0]  result_q;
   logic [31:0]  lut_pair;

   logic         is_req;
   logic         is_stats;
   logic [2:0]   req_cnt;
   logic         req_zero;
   logic         req_enq;
   logic         accept;
   logic         pop;
   logic         slot_free;
   logic         wr_pend;
   logic         wr_req;
   logic         wr_en;
   logic         tail;
   queue_entry_t wr_entry;
   logic         unused_bits;

`ifdef OPTIC_FLOW_SEQ_STATS_EN
   logic [31:0]  stat_count;
   assign is_stats    = is_req && valueB[31];
   assign unused_bits = ^valueB[30:3];
`else
   assign is_stats    = 1'b0;
   assign unused_bits = ^valueB[31:3];
`endif

   optic_flow_color_lut u_lut (
      .flowByte  (shift_data[7:0]),
      .pixelPair (lut_pair)
   );

   assign pixelValid = (state == ST_EMIT);
   assign pixelData  = pixelValid ? lut_pair : '0;
   assign done       = done_q;
   assign result     = result_q;

   // The head entry keeps its slot until its last byte is accepted, so the
   // queue counts the word being emitted plus one waiting word.
   always_comb begin
      is_req    = start && (ciN == customInstructionId) && !pend;
      req_cnt   = clamp_count(valueB[2:0]);
      req_zero  = is_req && !is_stats && (req_cnt == 3'd0);
      req_enq   = is_req && !is_stats && (req_cnt != 3'd0);
      accept    = pixelValid && pixelReady;
      pop       = accept && (rem == 3'd1);
      slot_free = (cnt != 2'(QUEUE_DEPTH)) || pop;
      wr_pend   = pend && slot_free;
      wr_req    = req_enq && slot_free;
      wr_en     = wr_pend || wr_req;
      // with two slots, head+cnt wraps onto the slot the pop is freeing
      tail      = head ^ cnt[0];
      wr_entry  = pend ? pend_entry : '{data: valueA, count: req_cnt};
      cnt_next  = cnt;
      if (pop && !wr_en)      cnt_next = cnt - 2'd1;
      else if (!pop && wr_en) cnt_next = cnt + 2'd1;
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
         head       <= 1'b0;
         cnt        <= '0;
         pend       <= 1'b0;
         pend_entry <= '0;
      end else begin
         if (wr_en) q[tail] <= wr_entry;
         if (pop)   head <= ~head;
         cnt <= cnt_next;
         if (req_enq && !slot_free) begin
            pend       <= 1'b1;
            pend_entry <= '{data: valueA, count: req_cnt};
         end else if (wr_pend) begin
            pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state      <= ST_IDLE;
         shift_data <= '0;
         rem        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cnt != 2'd0) begin
                  shift_data <= q[head].data;
                  rem        <= q[head].count;
                  state      <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (pop) begin
                  if (cnt == 2'(QUEUE_DEPTH)) begin
                     shift_data <= q[~head].data;
                     rem        <= q[~head].count;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (accept) begin
                  shift_data <= {8'h00, shift_data[31:8]};
                  rem        <= rem - 3'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q   <= is_stats || req_zero || wr_req || wr_pend;
         result_q <= '0;
`ifdef OPTIC_FLOW_SEQ_STATS_EN
         if (is_stats) result_q <= stat_count;
`endif
      end
   end

`ifdef OPTIC_FLOW_SEQ_STATS_EN
   // a read clears the counter; an acceptance on the same edge counts after it
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset)       stat_count <= '0;
      else if (is_stats) stat_count <= accept ? 32'd1 : 32'd0;
      else if (accept)   stat_count <= stat_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_optic_flow_color_seq.sv
module tb_optic_flow_color_seq;

   logic        clock = 1'b0;
   logic        nReset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  ciN = 8'd0;
   logic [31:0] valueA = '0;
   logic [31:0] valueB = '0;
   logic        done;
   logic [31:0] result;
   logic [31:0] pixelData;
   logic        pixelValid;
   logic        pixelReady = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_q [$];

   logic [15:0] ref_lut [16] = '{
      16'h0000, 16'h0400, 16'h8000, 16'h0010,
      16'h8410, 16'h8410, 16'h0410, 16'h8400,
      16'hC618, 16'hF800, 16'h8010, 16'h07E0,
      16'h001F, 16'hFFE0, 16'h07FF, 16'hFFFF
   };

   optic_flow_color_seq #(.customInstructionId(8'd31)) dut (
      .clock      (clock),
      .nReset     (nReset),
      .start      (start),
      .ciN        (ciN),
      .valueA     (valueA),
      .valueB     (valueB),
      .done       (done),
      .result     (result),
      .pixelData  (pixelData),
      .pixelValid (pixelValid),
      .pixelReady (pixelReady)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_pair(input logic [7:0] b);
      return {ref_lut[b[7:4]], ref_lut[b[3:0]]};
   endfunction

   // expected output words of one flow word, in emission order
   task automatic push_expected(input logic [31:0] a, input logic [2:0] c);
      int n;
      n = (c > 3'd4) ? 4 : int'(c);
      for (int i = 0; i < n; i++) exp_q.push_back(ref_pair(a[8*i +: 8]));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0;
      pixelReady = 1'b0;
      nReset = 1'b0;
      #7;
      nReset = 1'b1;
      tick();
      exp_q.delete();
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      #3;
      tick();
      tick();
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      checks++;
      if (pixelValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pixelValid); end
      checks++;
      if (pixelData !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", pixelData); end
      checks++;
      do_reset();
   endtask

   task automatic test_basic();
      logic [31:0] want [3];
      want[0] = 32'h00000400; want[1] = 32'h80108410; want[2] = 32'h84108000;
      pixelReady = 1'b1;
      ciN = 8'd31; valueA = 32'h0042A501; valueB = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
      checks++;
      if (result !== 32'h0) begin failures++; $display("FAIL basic_result got=%h exp=0", result); end
      checks++;
      if (pixelValid !== 1'b0) begin failures++; $display("FAIL basic_valid_c1 got=%b exp=0", pixelValid); end
      checks++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (pixelValid !== 1'b1 || pixelData !== want[i]) begin
            failures++;
            $display("FAIL basic_word%0d got=%b/%h exp=1/%h", i, pixelValid, pixelData, want[i]);
         end
         checks++;
      end
      tick();
      if (pixelValid !== 1'b0) begin failures++; $display("FAIL basic_valid_c5 got=%b exp=0", pixelValid); end
      checks++;
      tick();
   endtask

   task automatic test_stall();
      pixelReady = 1'b0;
      ciN = 8'd31; valueA = 32'h0042A501; valueB = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
      checks++;
      for (int c = 2; c <= 6; c++) begin
         tick();
         if (c == 6) pixelReady = 1'b1;
         if (pixelValid !== 1'b1 || pixelData !== 32'h00000400) begin
            failures++;
            $display("FAIL stall_hold_c%0d got=%b/%h exp=1/00000400", c, pixelValid, pixelData);
         end
         checks++;
      end
      tick();
      if (pixelData !== 32'h80108410) begin failures++; $display("FAIL stall_c7 got=%h exp=80108410", pixelData); end
      checks++;
      tick();
      if (pixelData !== 32'h84108000) begin failures++; $display("FAIL stall_c8 got=%h exp=84108000", pixelData); end
      checks++;
      tick();
      if (pixelValid !== 1'b0) begin failures++; $display("FAIL stall_c9_valid got=%b exp=0", pixelValid); end
      checks++;
   endtask

   // three count-4 words issued while the stream is stalled; the third waits
   task automatic issue_three_stalled(input string tag);
      logic [31:0] a;
      pixelReady = 1'b0;
      for (int r = 0; r < 3; r++) begin
         a = $urandom;
         push_expected(a, 3'd4);
         ciN = 8'd31; valueA = a; valueB = 32'd4; start = 1'b1;
         tick();
         start = 1'b0;
         if (done !== (r < 2)) begin
            failures++;
            $display("FAIL %s_done_req%0d got=%b exp=%b", tag, r, done, (r < 2));
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      exp_q.delete();
      issue_three_stalled("b2b");
      for (int k = 0; k < 3; k++) begin
         if (done !== 1'b0) begin failures++; $display("FAIL b2b_wait_done got=%b exp=0", done); end
         checks++;
         tick();
      end
      pixelReady = 1'b1;
      for (int i = 0; i < 12; i++) begin
         w = exp_q.pop_front();
         if (pixelValid !== 1'b1 || pixelData !== w) begin
            failures++;
            $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", i, pixelValid, pixelData, w);
         end
         checks++;
         if (done !== (i == 4)) begin
            failures++;
            $display("FAIL b2b_done_slot%0d got=%b exp=%b", i, done, (i == 4));
         end
         checks++;
         tick();
      end
      if (pixelValid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", pixelValid); end
      checks++;
   endtask

   task automatic test_edge_counts();
      int n;
      logic [31:0] a;
      logic [31:0] w;
      pixelReady = 1'b1;
      exp_q.delete();
      // zero count: acknowledged, no output
      ciN = 8'd31; valueA = 32'hFFFFFFFF; valueB = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
      checks++;
      n = 0;
      for (int k = 0; k < 5; k++) begin if (pixelValid) n++; tick(); end
      if (n != 0) begin failures++; $display("FAIL zero_words got=%0d exp=0", n); end
      checks++;
      // count 7 clamps to 4
      a = $urandom;
      push_expected(a, 3'd7);
      valueA = a; valueB = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      if (done !== 1'b1) begin failures++; $display("FAIL clamp_done got=%b exp=1", done); end
      checks++;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (pixelValid) begin
            n++;
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            if (pixelData !== w) begin failures++; $display("FAIL clamp_word%0d got=%h exp=%h", n, pixelData, w); end
            checks++;
         end
         tick();
      end
      if (n != 4) begin failures++; $display("FAIL clamp_words got=%0d exp=4", n); end
      checks++;
      // foreign instruction number is ignored
      ciN = 8'd47; valueA = 32'h12345678; valueB = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      ciN = 8'd31;
      n = 0;
      for (int k = 0; k < 6; k++) begin if (pixelValid || done) n++; tick(); end
      if (n != 0) begin failures++; $display("FAIL foreign_ci got=%0d active cycles exp=0", n); end
      checks++;
`ifndef OPTIC_FLOW_SEQ_STATS_EN
      // without statistics, bit 31 is an ordinary enqueue
      valueA = 32'h0042A501; valueB = 32'h80000003; start = 1'b1;
      tick();
      start = 1'b0;
      if (done !== 1'b1) begin failures++; $display("FAIL b31_done got=%b exp=1", done); end
      checks++;
      n = 0;
      for (int k = 0; k < 8; k++) begin if (pixelValid) n++; tick(); end
      if (n != 3) begin failures++; $display("FAIL b31_words got=%0d exp=3", n); end
      checks++;
`endif
   endtask

   task automatic test_reset_mid();
      int n;
      exp_q.delete();
      issue_three_stalled("rmid");
      pixelReady = 1'b1;
      tick();
      if (pixelValid !== 1'b1) begin failures++; $display("FAIL rmid_word2_valid got=%b exp=1", pixelValid); end
      checks++;
      #2;
      nReset = 1'b0;
      #1;
      if (pixelValid !== 1'b0 || pixelData !== 32'h0) begin
         failures++;
         $display("FAIL rmid_async got=%b/%h exp=0/0", pixelValid, pixelData);
      end
      checks++;
      #2;
      nReset = 1'b1;
      tick();
      n = 0;
      for (int k = 0; k < 12; k++) begin if (pixelValid || done) n++; tick(); end
      if (n != 0) begin failures++; $display("FAIL rmid_after got=%0d active cycles exp=0", n); end
      checks++;
      exp_q.delete();
   endtask

   task automatic test_random();
      bit outstanding = 0;
      bit prev_stall = 0;
      logic [31:0] prev_data = '0;
      logic [31:0] a;
      logic [31:0] w;
      int n_req = 0;
      int n_done = 0;
      int wait_cyc = 0;
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         pixelReady = ($urandom_range(0, 3) != 0);
         if (done) begin
            if (!outstanding) begin failures++; $display("FAIL rnd_spurious_done cyc=%0d got=1 exp=0", cyc); end
            checks++;
            if (result !== 32'h0) begin failures++; $display("FAIL rnd_result got=%h exp=0", result); end
            checks++;
            outstanding = 0;
            n_done++;
         end
         if (outstanding) begin
            wait_cyc++;
            if (wait_cyc > 60) begin
               failures++;
               $display("FAIL rnd_done_timeout got=none exp=done");
               outstanding = 0;
            end
         end
         if (prev_stall) begin
            if (pixelValid !== 1'b1 || pixelData !== prev_data) begin
               failures++;
               $display("FAIL rnd_stall_hold got=%b/%h exp=1/%h", pixelValid, pixelData, prev_data);
            end
            checks++;
         end
         if (pixelValid && pixelReady) begin
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            if (pixelData !== w) begin failures++; $display("FAIL rnd_word got=%h exp=%h", pixelData, w); end
            checks++;
         end
         prev_stall = pixelValid && !pixelReady;
         prev_data = pixelData;
         start = 1'b0;
         if (!outstanding && n_req < 150 && $urandom_range(0, 2) == 0) begin
            a = $urandom;
            valueA = a;
            valueB = $urandom & 32'h7FFFFFFF;
            start = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
               ciN = 8'd30;
            end else begin
               ciN = 8'd31;
               push_expected(a, valueB[2:0]);
               outstanding = 1;
               wait_cyc = 0;
               n_req++;
            end
         end
         tick();
      end
      start = 1'b0;
      ciN = 8'd31;
      if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d left exp=0", exp_q.size()); end
      checks++;
      if (n_done != n_req) begin failures++; $display("FAIL rnd_done_count got=%0d exp=%0d", n_done, n_req); end
      checks++;
   endtask

`ifdef OPTIC_FLOW_SEQ_STATS_EN
   task automatic test_stats();
      do_reset();
      pixelReady = 1'b1;
      ciN = 8'd31;
      valueA = $urandom; valueB = 32'd3; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      valueA = $urandom; valueB = 32'd4; start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      valueB = 32'h80000000; start = 1'b1; tick(); start = 1'b0;
      if (done !== 1'b1 || result !== 32'd7) begin
         failures++;
         $display("FAIL stats_read1 got=%b/%0d exp=1/7", done, result);
      end
      checks++;
      tick();
      valueB = 32'h80000000; start = 1'b1; tick(); start = 1'b0;
      if (done !== 1'b1 || result !== 32'd0) begin
         failures++;
         $display("FAIL stats_read2 got=%b/%0d exp=1/0", done, result);
      end
      checks++;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_edge_counts();
      test_reset_mid();
      test_random();
`ifdef OPTIC_FLOW_SEQ_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
